// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared decode constants and the per-stage control record
// for the pipe_ctrl pipeline controller.
//   - opcode / funct field encodings of the supported instruction subset
//   - ALU control encodings
//   - ctrl_t: packed control bundle carried from decode into the E stage
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       branch;
    logic       alusrc;
    logic       regdst;
    logic [2:0] aluctl;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational main/ALU decoder for the D stage.
// Ports:
//   i_op, i_funct  D-stage opcode and function fields
//   o_ctrl         control bundle (all zero for an illegal instruction)
//   o_jump         J instruction in D
//   o_illegal      unknown opcode, or unknown funct with an R-type opcode
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output ctrl_t      o_ctrl,
  output logic       o_jump,
  output logic       o_illegal
);

  always_comb begin
    o_ctrl    = '0;
    o_jump    = 1'b0;
    o_illegal = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.regdst   = 1'b1;
        case (i_funct)
          FN_ADD:  o_ctrl.aluctl = ALU_ADD;
          FN_SUB:  o_ctrl.aluctl = ALU_SUB;
          FN_AND:  o_ctrl.aluctl = ALU_AND;
          FN_OR:   o_ctrl.aluctl = ALU_OR;
          FN_SLT:  o_ctrl.aluctl = ALU_SLT;
          default: begin
            o_ctrl    = '0;
            o_illegal = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.memtoreg = 1'b1;
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.aluctl   = ALU_ADD;
      end
      OP_SW: begin
        o_ctrl.memwrite = 1'b1;
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.aluctl   = ALU_ADD;
      end
      OP_BEQ: begin
        o_ctrl.branch = 1'b1;
        o_ctrl.aluctl = ALU_SUB;
      end
      OP_ADDI: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.aluctl   = ALU_ADD;
      end
      OP_J:    o_jump    = 1'b1;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: control path of a pipeline E -> M1..M<MEM_STAGES> -> W.
// Decoded controls are carried down the stage registers with a valid bit;
// every stage output is its control gated by that stage's valid.
// Parameters:
//   MEM_STAGES  memory stages between E and W (1..3)
//   ALUC_W      width of alucontrol_e (>=3, upper bits driven 0)
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   op, funct             D-stage instruction fields
//   zero_m                ALU zero flag of the M1 instruction
//   stall, flush_e        hold all stages / bubble into E
//   jump_d, illegal_d     D-stage decode flags (combinational)
//   *_e, *_m, *_w         per-stage controls
//   pcsrc_m               taken branch in M1
//   retired_cnt           retired-instruction count
// Build option: define PIPE_CTRL_PERF_EN to build the retired counter;
// otherwise retired_cnt is tied to 0.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_STAGES = 1,
  parameter int unsigned ALUC_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic              zero_m,
  input  logic              stall,
  input  logic              flush_e,
  output logic              jump_d,
  output logic              illegal_d,
  output logic              alusrc_e,
  output logic              regdst_e,
  output logic [ALUC_W-1:0] alucontrol_e,
  output logic              regwrite_e,
  output logic              memtoreg_e,
  output logic              regwrite_m,
  output logic              memtoreg_m,
  output logic              memwrite_m,
  output logic              pcsrc_m,
  output logic              regwrite_w,
  output logic              memtoreg_w,
  output logic [31:0]       retired_cnt
);

  ctrl_t w_dec;
  logic  w_jump;
  logic  w_illegal;
  logic  w_pcsrc;

  logic                  r_e_valid;
  ctrl_t                 r_e;
  // Index 0 is M1; memwrite and branch only exist in M1.
  logic [MEM_STAGES-1:0] r_m_valid;
  logic [MEM_STAGES-1:0] r_m_regwrite;
  logic [MEM_STAGES-1:0] r_m_memtoreg;
  logic                  r_m1_memwrite;
  logic                  r_m1_branch;
  logic                  r_w_valid;
  logic                  r_w_regwrite;
  logic                  r_w_memtoreg;

  ctrl_decode u_dec (
    .i_op      (op),
    .i_funct   (funct),
    .o_ctrl    (w_dec),
    .o_jump    (w_jump),
    .o_illegal (w_illegal)
  );

  assign w_pcsrc = r_m1_branch & zero_m & r_m_valid[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e_valid     <= 1'b0;
      r_e           <= '0;
      r_m_valid     <= '0;
      r_m_regwrite  <= '0;
      r_m_memtoreg  <= '0;
      r_m1_memwrite <= 1'b0;
      r_m1_branch   <= 1'b0;
      r_w_valid     <= 1'b0;
      r_w_regwrite  <= 1'b0;
      r_w_memtoreg  <= 1'b0;
    end else if (!stall) begin
      // An illegal instruction enters E as a bubble so it never retires.
      if (flush_e || w_pcsrc) begin
        r_e_valid <= 1'b0;
        r_e       <= '0;
      end else begin
        r_e_valid <= ~w_illegal;
        r_e       <= w_dec;
      end
      if (w_pcsrc) begin
        r_m_valid[0]    <= 1'b0;
        r_m_regwrite[0] <= 1'b0;
        r_m_memtoreg[0] <= 1'b0;
        r_m1_memwrite   <= 1'b0;
        r_m1_branch     <= 1'b0;
      end else begin
        r_m_valid[0]    <= r_e_valid;
        r_m_regwrite[0] <= r_e.regwrite;
        r_m_memtoreg[0] <= r_e.memtoreg;
        r_m1_memwrite   <= r_e.memwrite;
        r_m1_branch     <= r_e.branch;
      end
      for (int unsigned k = 1; k < MEM_STAGES; k++) begin
        r_m_valid[k]    <= r_m_valid[k-1];
        r_m_regwrite[k] <= r_m_regwrite[k-1];
        r_m_memtoreg[k] <= r_m_memtoreg[k-1];
      end
      r_w_valid    <= r_m_valid[MEM_STAGES-1];
      r_w_regwrite <= r_m_regwrite[MEM_STAGES-1];
      r_w_memtoreg <= r_m_memtoreg[MEM_STAGES-1];
    end
  end

  assign jump_d       = w_jump;
  assign illegal_d    = w_illegal;
  assign alusrc_e     = r_e_valid & r_e.alusrc;
  assign regdst_e     = r_e_valid & r_e.regdst;
  assign alucontrol_e = ALUC_W'(r_e.aluctl & {3{r_e_valid}});
  assign regwrite_e   = r_e_valid & r_e.regwrite;
  assign memtoreg_e   = r_e_valid & r_e.memtoreg;
  assign regwrite_m   = r_m_valid[0] & r_m_regwrite[0];
  assign memtoreg_m   = r_m_valid[0] & r_m_memtoreg[0];
  assign memwrite_m   = r_m_valid[0] & r_m1_memwrite;
  assign pcsrc_m      = w_pcsrc;
  assign regwrite_w   = r_w_valid & r_w_regwrite;
  assign memtoreg_w   = r_w_valid & r_w_memtoreg;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_retired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (!stall && r_w_valid) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign retired_cnt = r_retired;
`else
  assign retired_cnt = '0;
`endif

endmodule
